wb_arbiter_q: RTL and testbench

- Parametrised write-back arbiter that merges results from NUM_PIPES execution pipes (ALU, LSU, MUL, DIV by default) into the single register-file write port consumed by IX.
- Generalises the fixed-priority WB selection. Each pipe gets its own per-pipe result queue with a valid/ready handshake, so a losing pipe back-pressures instead of dropping or stalling globally.
- Arbitration mode is selectable: fixed priority or round-robin.
- Exports a pending-destination mask that IX uses for RAW hazard checks.

---
 rtl/wb_arbiter_q.sv | 149 ++++++++++++++
 tb/tb_wb_arbiter_q.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_q.sv
// Write-back arbiter: per-pipe result FIFOs merged into one register-file write port.
// Fixed-priority or round-robin selection; exports a pending-destination mask for hazard checks.
module wb_arbiter_q #(
    parameter int unsigned NUM_PIPES   = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned REG_WIDTH   = 5,
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned QUEUE_DEPTH = 2,
    parameter int unsigned RR_MODE     = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PIPES-1:0]             pipe_valid,
    output logic [NUM_PIPES-1:0]             pipe_ready,
    input  logic [NUM_PIPES-1:0]             pipe_wr_en,
    input  logic [NUM_PIPES*REG_WIDTH-1:0]   pipe_rd,
    input  logic [NUM_PIPES*DATA_WIDTH-1:0]  pipe_data,
    output logic                             wb_wr_en,
    output logic [REG_WIDTH-1:0]             wb_rd,
    output logic [DATA_WIDTH-1:0]            wb_wr_data,
    output logic [NUM_PIPES-1:0]             wb_grant,
    output logic [NUM_REGS-1:0]              rd_pending
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

    logic [REG_WIDTH-1:0]  q_rd   [NUM_PIPES][QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] q_data [NUM_PIPES][QUEUE_DEPTH];
    logic [PTR_W-1:0]      wr_ptr [NUM_PIPES];
    logic [PTR_W-1:0]      rd_ptr [NUM_PIPES];
    logic [CNT_W-1:0]      count  [NUM_PIPES];

    logic [NUM_PIPES-1:0]  req;
    logic [NUM_PIPES-1:0]  push;
    logic [NUM_PIPES-1:0]  grant_oh;
    logic                  grant_vld;
    logic [IDX_W-1:0]      grant_idx;
    logic [IDX_W-1:0]      rr_ptr;
    logic [REG_WIDTH-1:0]  head_rd;
    logic [DATA_WIDTH-1:0] head_data;

    // Ready ignores a same-cycle pop so it depends only on registered state.
    always_comb begin
        pipe_ready = '0;
        req        = '0;
        push       = '0;
        for (int i = 0; i < int'(NUM_PIPES); i++) begin
            pipe_ready[i] = (count[i] != CNT_W'(QUEUE_DEPTH));
            req[i]        = (count[i] != '0);
            push[i]       = pipe_valid[i] && (count[i] != CNT_W'(QUEUE_DEPTH)) &&
                            pipe_wr_en[i] && (pipe_rd[i*REG_WIDTH +: REG_WIDTH] != '0);
        end
    end

    // Downward scans so the last hit is the highest-priority candidate.
    always_comb begin
        int idx;
        logic [IDX_W-1:0] cand;
        idx       = 0;
        cand      = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        if (RR_MODE == 0) begin
            for (int i = int'(NUM_PIPES) - 1; i >= 0; i--) begin
                cand = IDX_W'(i);
                if (req[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end else begin
            for (int k = int'(NUM_PIPES); k >= 1; k--) begin
                idx  = (int'(rr_ptr) + k) % int'(NUM_PIPES);
                cand = IDX_W'(idx);
                if (req[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        grant_oh = '0;
        if (grant_vld) grant_oh[grant_idx] = 1'b1;
        head_rd   = q_rd[grant_idx][rd_ptr[grant_idx]];
        head_data = q_data[grant_idx][rd_ptr[grant_idx]];
    end

    // Pending mask: every live queue slot plus the write currently on the port.
    always_comb begin
        logic [PTR_W-1:0] off;
        off        = '0;
        rd_pending = '0;
        for (int i = 0; i < int'(NUM_PIPES); i++) begin
            for (int j = 0; j < int'(QUEUE_DEPTH); j++) begin
                off = PTR_W'(j) - rd_ptr[i];
                if ({1'b0, off} < count[i]) rd_pending[q_rd[i][j]] = 1'b1;
            end
        end
        if (wb_wr_en) rd_pending[wb_rd] = 1'b1;
        rd_pending[0] = 1'b0;
    end

    // Queue storage carries no reset; validity comes from the counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_PIPES); i++) begin
            if (push[i]) begin
                q_rd[i][wr_ptr[i]]   <= pipe_rd[i*REG_WIDTH +: REG_WIDTH];
                q_data[i][wr_ptr[i]] <= pipe_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_PIPES); i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr     <= IDX_W'(NUM_PIPES - 1);
            wb_wr_en   <= 1'b0;
            wb_rd      <= '0;
            wb_wr_data <= '0;
            wb_grant   <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_PIPES); i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (grant_oh[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                case ({push[i], grant_oh[i]})
                    2'b10:   count[i] <= count[i] + CNT_W'(1);
                    2'b01:   count[i] <= count[i] - CNT_W'(1);
                    default: count[i] <= count[i];
                endcase
            end
            if (grant_vld) begin
                wb_wr_en   <= 1'b1;
                wb_rd      <= head_rd;
                wb_wr_data <= head_data;
                wb_grant   <= grant_oh;
                rr_ptr     <= grant_idx;
            end else begin
                wb_wr_en   <= 1'b0;
                wb_grant   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter_q.sv
// Directed bench for wb_arbiter_q: a vector table on a fixed-priority instance,
// plus sequences for back-pressure, round-robin and mid-flight reset.
module tb_wb_arbiter_q;

    localparam int unsigned NP = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned NR = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP-1:0]   pipe_valid, pipe_ready, pipe_wr_en, wb_grant;
    logic [NP*RW-1:0] pipe_rd;
    logic [NP*DW-1:0] pipe_data;
    logic            wb_wr_en;
    logic [RW-1:0]   wb_rd;
    logic [DW-1:0]   wb_wr_data;
    logic [NR-1:0]   rd_pending;

    logic [NP-1:0]   rr_valid, rr_ready, rr_wr_en, rr_grant;
    logic [NP*RW-1:0] rr_rd;
    logic [NP*DW-1:0] rr_data;
    logic            rr_wb_wr_en;
    logic [RW-1:0]   rr_wb_rd;
    logic [DW-1:0]   rr_wb_data;
    logic [NR-1:0]   rr_pending;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_arbiter_q #(.NUM_PIPES(NP), .DATA_WIDTH(DW), .REG_WIDTH(RW), .NUM_REGS(NR),
                   .QUEUE_DEPTH(2), .RR_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_wr_en(pipe_wr_en),
        .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_wr_data(wb_wr_data),
        .wb_grant(wb_grant), .rd_pending(rd_pending)
    );

    wb_arbiter_q #(.NUM_PIPES(NP), .DATA_WIDTH(DW), .REG_WIDTH(RW), .NUM_REGS(NR),
                   .QUEUE_DEPTH(2), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst(rst),
        .pipe_valid(rr_valid), .pipe_ready(rr_ready), .pipe_wr_en(rr_wr_en),
        .pipe_rd(rr_rd), .pipe_data(rr_data),
        .wb_wr_en(rr_wb_wr_en), .wb_rd(rr_wb_rd), .wb_wr_data(rr_wb_data),
        .wb_grant(rr_grant), .rd_pending(rr_pending)
    );

    typedef struct {
        logic [NP-1:0]    valid;
        logic [NP-1:0]    wr_en;
        logic [NP*RW-1:0] rd;
        logic [NP*DW-1:0] data;
        logic             e_wr_en;
        logic [RW-1:0]    e_rd;
        logic [DW-1:0]    e_data;
        logic [NP-1:0]    e_grant;
        logic [NP-1:0]    e_ready;
        logic [NR-1:0]    e_pend;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [NP*RW-1:0] mk_rd(input int r0, input int r1, input int r2, input int r3);
        return {RW'(r3), RW'(r2), RW'(r1), RW'(r0)};
    endfunction

    function automatic logic [NP*DW-1:0] mk_data(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                                 input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_valid = '0;
        pipe_wr_en = '0;
        pipe_rd    = '0;
        pipe_data  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p1_idx, got, p;
        logic acc1;
        logic [NP-1:0] exp_g;

        rst = 1'b1;
        idle_inputs();
        rr_valid = '0; rr_wr_en = '0; rr_rd = '0; rr_data = '0;

        //                  valid    wr_en    rd                  data                                     wr  rd  data          grant    ready    pend
        vecs[0] = '{4'b0100, 4'b0100, mk_rd(0,0,7,0), mk_data(0, 0, 32'hDEADBEEF, 0),             1'b0, 5'd0, 32'h0,        4'b0000, 4'b1111, 32'h80};
        vecs[1] = '{4'b0000, 4'b0000, mk_rd(0,0,0,0), mk_data(0, 0, 0, 0),                        1'b1, 5'd7, 32'hDEADBEEF, 4'b0100, 4'b1111, 32'h80};
        vecs[2] = '{4'b0000, 4'b0000, mk_rd(0,0,0,0), mk_data(0, 0, 0, 0),                        1'b0, 5'd7, 32'hDEADBEEF, 4'b0000, 4'b1111, 32'h0};
        vecs[3] = '{4'b1011, 4'b1011, mk_rd(1,2,9,3), mk_data(32'h11, 32'h22, 32'h99, 32'h33),    1'b0, 5'd7, 32'hDEADBEEF, 4'b0000, 4'b1111, 32'hE};
        vecs[4] = '{4'b0000, 4'b0000, mk_rd(0,0,0,0), mk_data(0, 0, 0, 0),                        1'b1, 5'd1, 32'h11,       4'b0001, 4'b1111, 32'hE};
        vecs[5] = '{4'b0000, 4'b0000, mk_rd(0,0,0,0), mk_data(0, 0, 0, 0),                        1'b1, 5'd2, 32'h22,       4'b0010, 4'b1111, 32'hC};
        vecs[6] = '{4'b0000, 4'b0000, mk_rd(0,0,0,0), mk_data(0, 0, 0, 0),                        1'b1, 5'd3, 32'h33,       4'b1000, 4'b1111, 32'h8};
        vecs[7] = '{4'b0000, 4'b0000, mk_rd(0,0,0,0), mk_data(0, 0, 0, 0),                        1'b0, 5'd3, 32'h33,       4'b0000, 4'b1111, 32'h0};
        vecs[8] = '{4'b0011, 4'b0010, mk_rd(5,0,0,0), mk_data(32'h5, 32'h6, 0, 0),                1'b0, 5'd3, 32'h33,       4'b0000, 4'b1111, 32'h0};
        vecs[9] = '{4'b0000, 4'b0000, mk_rd(0,0,0,0), mk_data(0, 0, 0, 0),                        1'b0, 5'd3, 32'h33,       4'b0000, 4'b1111, 32'h0};

        #12;
        rst = 1'b0;
        #1;
        chk("reset wb_wr_en",   64'(wb_wr_en),   64'h0);
        chk("reset wb_rd",      64'(wb_rd),      64'h0);
        chk("reset wb_wr_data", 64'(wb_wr_data), 64'h0);
        chk("reset wb_grant",   64'(wb_grant),   64'h0);
        chk("reset rd_pending", 64'(rd_pending), 64'h0);
        chk("reset pipe_ready", 64'(pipe_ready), 64'hF);

        // Single pipe, fixed-priority contention and discard cases.
        for (int v = 0; v < 10; v++) begin
            pipe_valid = vecs[v].valid;
            pipe_wr_en = vecs[v].wr_en;
            pipe_rd    = vecs[v].rd;
            pipe_data  = vecs[v].data;
            tick();
            chk($sformatf("vec%0d wb_wr_en", v),   64'(wb_wr_en),   64'(vecs[v].e_wr_en));
            chk($sformatf("vec%0d wb_rd", v),      64'(wb_rd),      64'(vecs[v].e_rd));
            chk($sformatf("vec%0d wb_wr_data", v), 64'(wb_wr_data), 64'(vecs[v].e_data));
            chk($sformatf("vec%0d wb_grant", v),   64'(wb_grant),   64'(vecs[v].e_grant));
            chk($sformatf("vec%0d pipe_ready", v), 64'(pipe_ready), 64'(vecs[v].e_ready));
            chk($sformatf("vec%0d rd_pending", v), 64'(rd_pending), 64'(vecs[v].e_pend));
        end
        idle_inputs();

        // Back-pressure: pipe 0 floods for 5 cycles while pipe 1 offers rd 10,11,12.
        p1_idx = 0;
        got    = 0;
        for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
            pipe_valid[0] = (cyc < 5);
            pipe_wr_en[0] = 1'b1;
            pipe_rd[0*RW +: RW]   = 5'd20;
            pipe_data[0*DW +: DW] = 32'h55;
            pipe_valid[1] = (p1_idx < 3);
            pipe_wr_en[1] = 1'b1;
            pipe_rd[1*RW +: RW]   = RW'(10 + p1_idx);
            pipe_data[1*DW +: DW] = DW'(32'hA0 + p1_idx);
            acc1 = pipe_valid[1] && pipe_ready[1];
            if (acc1 && p1_idx == 2)
                chk("bp third accepted only after pipe1 grant", 64'(got >= 1), 64'h1);
            tick();
            if (acc1) begin
                p1_idx++;
                if (p1_idx == 2) chk("bp pipe_ready[1] after 2 accepts", 64'(pipe_ready[1]), 64'h0);
            end
            if (wb_wr_en && wb_grant[1]) begin
                chk($sformatf("bp order rd #%0d", got),   64'(wb_rd),      64'(10 + got));
                chk($sformatf("bp order data #%0d", got), 64'(wb_wr_data), 64'(32'hA0 + got));
                got++;
            end
        end
        chk("bp all three written back", 64'(got), 64'd3);
        idle_inputs();
        repeat (4) tick();
        chk("bp drained pending", 64'(rd_pending), 64'h0);

        // Round-robin with every pipe kept busy.
        rr_wr_en = 4'b1111;
        rr_rd    = mk_rd(1, 2, 3, 4);
        rr_data  = mk_data(32'hA, 32'hB, 32'hC, 32'hD);
        rr_valid = 4'b1111;
        tick();
        chk("rr first edge idle", 64'(rr_wb_wr_en), 64'h0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            p     = (k - 1) % 4;
            exp_g = 4'b0001 << p;
            chk($sformatf("rr grant k%0d", k), 64'(rr_grant),   64'(exp_g));
            chk($sformatf("rr rd k%0d", k),    64'(rr_wb_rd),   64'(p + 1));
            chk($sformatf("rr data k%0d", k),  64'(rr_wb_data), 64'(32'hA + p));
        end
        rr_valid = '0;
        repeat (10) tick();

        // Reset with three entries still queued and a write on the port.
        pipe_valid = 4'b1111;
        pipe_wr_en = 4'b1111;
        pipe_rd    = mk_rd(4, 5, 6, 8);
        pipe_data  = mk_data(32'h40, 32'h50, 32'h60, 32'h80);
        tick();
        idle_inputs();
        tick();
        chk("rst pre wb_wr_en", 64'(wb_wr_en), 64'h1);
        chk("rst pre wb_rd",    64'(wb_rd),    64'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("rst async wb_wr_en",   64'(wb_wr_en),   64'h0);
        chk("rst async rd_pending", 64'(rd_pending), 64'h0);
        chk("rst async pipe_ready", 64'(pipe_ready), 64'hF);
        chk("rst async wb_grant",   64'(wb_grant),   64'h0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("post-rst wb_wr_en c%0d", c),   64'(wb_wr_en),   64'h0);
            chk($sformatf("post-rst rd_pending c%0d", c), 64'(rd_pending), 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
